// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: latches a PAT_W-bit pattern on start and shifts it out MSB first,
// repeated repeat_cnt+1 times with GAP idle cycles between repetitions, then pulses done.
module seq_pattern_tx #(
  parameter int PAT_W = 3,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [3:0]       repeat_cnt,
  output logic             seq_out,
  output logic             busy,
  output logic             done,
  output logic [1:0]       crnt_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_GAP   = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam logic [3:0] BIT_LAST = 4'(PAT_W - 1);
  localparam logic [3:0] GAP_LOAD = 4'(GAP - 1);

  state_t           state, state_nxt;
  logic [PAT_W-1:0] shift_reg, shift_nxt;
  logic [PAT_W-1:0] pat_copy, pat_copy_nxt;
  logic [3:0]       bit_cnt, bit_cnt_nxt;
  logic [3:0]       reps_left, reps_left_nxt;
  logic [3:0]       gap_cnt, gap_cnt_nxt;
  logic             seq_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      shift_reg <= '0;
      pat_copy  <= '0;
      bit_cnt   <= '0;
      reps_left <= '0;
      gap_cnt   <= '0;
      seq_out   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      pat_copy  <= pat_copy_nxt;
      bit_cnt   <= bit_cnt_nxt;
      reps_left <= reps_left_nxt;
      gap_cnt   <= gap_cnt_nxt;
      seq_out   <= seq_nxt;
      busy      <= (state_nxt == S_SHIFT) || (state_nxt == S_GAP);
      done      <= (state_nxt == S_DONE);
    end
  end

  always_comb begin
    state_nxt     = state;
    shift_nxt     = shift_reg;
    pat_copy_nxt  = pat_copy;
    bit_cnt_nxt   = bit_cnt;
    reps_left_nxt = reps_left;
    gap_cnt_nxt   = gap_cnt;
    seq_nxt       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt     = S_SHIFT;
          shift_nxt     = pattern;
          pat_copy_nxt  = pattern;
          reps_left_nxt = repeat_cnt;
          bit_cnt_nxt   = BIT_LAST;
          seq_nxt       = pattern[PAT_W-1];
        end
      end
      S_SHIFT: begin
        if (bit_cnt != 4'd0) begin
          shift_nxt   = {shift_reg[PAT_W-2:0], 1'b0};
          seq_nxt     = shift_reg[PAT_W-2];
          bit_cnt_nxt = bit_cnt - 4'd1;
        end else if (reps_left == 4'd0) begin
          state_nxt = S_DONE;
        end else if (GAP > 0) begin
          state_nxt     = S_GAP;
          gap_cnt_nxt   = GAP_LOAD;
          reps_left_nxt = reps_left - 4'd1;
        end else begin
          // Reload from the latched copy so the next repetition follows without a bubble
          shift_nxt     = pat_copy;
          seq_nxt       = pat_copy[PAT_W-1];
          bit_cnt_nxt   = BIT_LAST;
          reps_left_nxt = reps_left - 4'd1;
        end
      end
      S_GAP: begin
        if (gap_cnt == 4'd0) begin
          state_nxt   = S_SHIFT;
          shift_nxt   = pat_copy;
          seq_nxt     = pat_copy[PAT_W-1];
          bit_cnt_nxt = BIT_LAST;
        end else begin
          gap_cnt_nxt = gap_cnt - 4'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign crnt_state = state;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: a GAP=0 and a GAP=2 instance checked cycle by cycle against
// a queue of expected {seq_out, busy, done, crnt_state} built from the timing description.
module tb_seq_pattern_tx;

  localparam int PW = 3;

  logic          clk;
  logic          reset;
  logic          start0, start2;
  logic [PW-1:0] pattern;
  logic [3:0]    repeat_cnt;
  logic          seq0, busy0, done0;
  logic [1:0]    st0;
  logic          seq2, busy2, done2;
  logic [1:0]    st2;

  int total = 0;
  int bad   = 0;
  logic [4:0] sb[$];

  seq_pattern_tx #(.PAT_W(PW), .GAP(0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .pattern(pattern), .repeat_cnt(repeat_cnt),
    .seq_out(seq0), .busy(busy0), .done(done0), .crnt_state(st0)
  );

  seq_pattern_tx #(.PAT_W(PW), .GAP(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .pattern(pattern), .repeat_cnt(repeat_cnt),
    .seq_out(seq2), .busy(busy2), .done(done2), .crnt_state(st2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected per-cycle outputs from cycle 1 after the accepting edge
  task automatic build_model(input logic [PW-1:0] pat, input int rep, input int gap, input int idles);
    for (int r = 0; r <= rep; r++) begin
      for (int b = PW - 1; b >= 0; b--) sb.push_back({pat[b], 1'b1, 1'b0, 2'b01});
      if (r < rep) for (int g = 0; g < gap; g++) sb.push_back(5'b0_1_0_10);
    end
    sb.push_back(5'b0_0_1_11);
    for (int i = 0; i < idles; i++) sb.push_back(5'b0_0_0_00);
  endtask

  task automatic run_tx(input bit sel, input logic [PW-1:0] pat, input logic [3:0] rep,
                        input bit iso, input string name);
    logic [4:0] exp_v, obs;
    int n;
    n = 0;
    @(negedge clk);
    pattern    = pat;
    repeat_cnt = rep;
    if (sel) start2 = 1'b1;
    else     start0 = 1'b1;
    sb.delete();
    build_model(pat, int'(rep), sel ? 2 : 0, iso ? 4 : 1);
    while (sb.size() > 0) begin
      @(negedge clk);
      n++;
      exp_v = sb.pop_front();
      obs   = sel ? {seq2, busy2, done2, st2} : {seq0, busy0, done0, st0};
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL %s cycle %0d: got %b want %b (seq,busy,done,state)", name, n, obs, exp_v);
      end
      start0 = 1'b0;
      start2 = 1'b0;
      if (iso && n == 2) begin
        pattern    = 3'b001;
        repeat_cnt = 4'd5;
        start0     = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    reset = 1'b1; start0 = 1'b1; start2 = 1'b1;
    pattern = 3'b101; repeat_cnt = 4'd0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      obs = {seq0, busy0, done0, st0, seq2, busy2, done2, st2};
      total++;
      if (obs !== 10'b0) begin
        bad++;
        $display("FAIL reset_hold cycle %0d: got %b want %b", i, obs, 10'b0);
      end
    end
    reset = 1'b0; start0 = 1'b0; start2 = 1'b0;
    @(negedge clk);
    obs = {seq0, busy0, done0, st0, seq2, busy2, done2, st2};
    total++;
    if (obs !== 10'b0) begin
      bad++;
      $display("FAIL reset_release: got %b want %b", obs, 10'b0);
    end
  endtask

  task automatic test_abort();
    logic [4:0] obs;
    logic [9:0] both;
    @(negedge clk);
    pattern = 3'b101; repeat_cnt = 4'd0; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    obs = {seq0, busy0, done0, st0};
    total++;
    if (obs !== 5'b1_1_0_01) begin
      bad++;
      $display("FAIL abort_c1: got %b want %b", obs, 5'b1_1_0_01);
    end
    @(negedge clk);
    obs = {seq0, busy0, done0, st0};
    total++;
    if (obs !== 5'b0_1_0_01) begin
      bad++;
      $display("FAIL abort_c2: got %b want %b", obs, 5'b0_1_0_01);
    end
    #2 reset = 1'b1;
    #1;
    both = {seq0, busy0, done0, st0, seq2, busy2, done2, st2};
    total++;
    if (both !== 10'b0) begin
      bad++;
      $display("FAIL abort_async: got %b want %b", both, 10'b0);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      obs = {seq0, busy0, done0, st0};
      total++;
      if (obs !== 5'b0) begin
        bad++;
        $display("FAIL abort_no_done cycle %0d: got %b want %b", i, obs, 5'b0);
      end
    end
    run_tx(1'b0, 3'b101, 4'd0, 1'b0, "abort_resend");
  endtask

  task automatic test_single();
    run_tx(1'b0, 3'b101, 4'd0, 1'b0, "single_101");
    run_tx(1'b0, 3'b011, 4'd0, 1'b0, "single_011");
  endtask

  task automatic test_back_to_back();
    run_tx(1'b0, 3'b101, 4'd2, 1'b0, "b2b_101x3");
    run_tx(1'b0, 3'b100, 4'd15, 1'b0, "b2b_100x16");
  endtask

  task automatic test_gap();
    run_tx(1'b1, 3'b101, 4'd1, 1'b0, "gap_101x2");
    run_tx(1'b1, 3'b110, 4'd3, 1'b0, "gap_110x4");
    run_tx(1'b1, 3'b111, 4'd0, 1'b0, "gap_single");
  endtask

  task automatic test_isolation();
    run_tx(1'b0, 3'b110, 4'd1, 1'b1, "isolation");
  endtask

  task automatic test_random();
    logic [PW-1:0] p;
    logic [3:0]    r;
    for (int i = 0; i < 4; i++) begin
      p = PW'($urandom_range(0, 7));
      r = 4'($urandom_range(0, 4));
      run_tx(i[0], p, r, 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_isolation();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern transmitter that drives a single-bit stream for the sequence-detector blocks. A start request latches a PAT_W-bit pattern and shifts it out MSB first, one bit per clock. It repeats the pattern a programmable number of times, inserting an optional idle gap between repetitions. It then pulses done and returns to idle. The block generates stimulus for, and sources data into, the serial sequence detectors (e.g. the 101 Mealy detector's seq_in).

## Interface
- PAT_W, default 3: pattern length in bits; legal range 2..16.
- GAP, default 0: idle cycles (seq_out=0) between repetitions; legal range 0..15. GAP=0 gives back-to-back repetitions.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  transmission request; sampled only in IDLE.
- pattern  input  PAT_W  bits to send; latched on the accepting edge, MSB sent first.
- repeat  input  4  extra repetitions; total transmissions = repeat+1 (1..16); latched with pattern.
- seq_out  output  1  registered serial data.
- busy  output  1  high in SHIFT and GAP.
- done  output  1  one-cycle pulse, high only in DONE.
- crnt_state  output  2  FSM state: IDLE=00, SHIFT=01, GAP=10, DONE=11.

## Operation
- Internal registers:
  - shift register, PAT_W bits.
  - bit counter, counts PAT_W-1 down to 0.
  - repetition counter, 4 bits, counts remaining extra transmissions.
  - gap counter, 4 bits.
- IDLE:
  - seq_out=0, busy=0, done=0.
  - start=1 at an edge loads shift_reg=pattern, reps_left=repeat, bit_cnt=PAT_W-1, and sets seq_out=pattern[PAT_W-1]; next state is SHIFT.
- SHIFT:
  - Each edge with bit_cnt>0: shift left, seq_out gets the next bit, bit_cnt decrements.
  - Edge with bit_cnt==0 (last bit just held for one cycle):
    - reps_left==0 → DONE, seq_out=0.
    - reps_left>0 and GAP>0 → GAP, gap_cnt=GAP-1, seq_out=0, reps_left decrements.
    - reps_left>0 and GAP==0 → stay in SHIFT; reload shift_reg from the latched pattern copy, seq_out=latched MSB, bit_cnt=PAT_W-1, reps_left decrements. The stream is contiguous, with no bubble.
- GAP:
  - seq_out=0, busy=1.
  - gap_cnt==0 at an edge → SHIFT with the same reload as above.
  - Otherwise gap_cnt decrements.
- DONE: lasts one cycle with done=1, busy=0, seq_out=0; returns to IDLE unconditionally.
- start is ignored in SHIFT, GAP and DONE. It is not queued.
- Changes to pattern and repeat after acceptance do not affect the transmission in flight. A latched pattern copy is held for reloads.
- Reset (asynchronous, any state, including mid-shift) forces:
  - state=IDLE;
  - seq_out=0, busy=0, done=0;
  - all counters and the shift register to 0.
- No done pulse is produced for an aborted transmission. Reset has priority over start.
- Reset values: seq_out=0, busy=0, done=0, crnt_state=00.

## Timing
- start is sampled at edge k. seq_out carries pattern[PAT_W-1] in cycle k+1 and pattern[0] in cycle k+PAT_W.
- One transmission occupies PAT_W cycles.
- Total busy cycles = (repeat+1)·PAT_W + repeat·GAP.
- done is high in the cycle immediately after the last data bit. IDLE follows one cycle later.
- The earliest new accepted start is at the edge ending the first IDLE cycle after DONE. The minimum start-to-start spacing is busy cycles + 2.
- Every output is a register output, with no combinational path from any input to an output.

## Test plan
- Reset check: hold reset for 2 cycles, including during an active start.
  - Required: crnt_state=00, seq_out=0, busy=0, done=0 throughout.
  - Required: the first accepted start occurs only after reset deasserts.
- Single shot, PAT_W=3, GAP=0, pattern=101, repeat=0, start pulse at edge 0.
  - Required: seq_out=1,0,1 in cycles 1–3, busy=1 in cycles 1–3.
  - Required: done=1 and crnt_state=11 in cycle 4; IDLE in cycle 5.
- Back-to-back, pattern=101, repeat=2, GAP=0.
  - Required: seq_out=101101101 over cycles 1–9, busy continuous, done in cycle 10.
- Gap insertion, GAP=2, pattern=101, repeat=1.
  - Required: seq_out=1,0,1,0,0,1,0,1 over cycles 1–8, crnt_state=10 in cycles 4–5, done in cycle 9.
- Input isolation: start pattern=110, repeat=1; in cycle 2, drive pattern=001, repeat=5, and pulse start.
  - Required: the stream is exactly 110110, followed by a single done.
  - Required: no second transmission starts.
- Abort: assert reset asynchronously mid-SHIFT (cycle 2, between edges) of a 101 send.
  - Required: seq_out=0, busy=0, crnt_state=00 immediately, with no done pulse.
  - Required: a subsequent start sends 101 normally.
